// File: rtl/spi_reg_slave_if.sv
// ----------------------------------------------------------------------------
// spi_reg_slave_if : SPI pin bundle between the SPI master and spi_reg_slave.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface spi_reg_slave_if;
  logic i_sclk;
  logic i_csn;
  logic i_mosi;
  logic o_miso;

  modport master (output i_sclk, output i_csn, output i_mosi, input o_miso);
  modport slave  (input i_sclk, input i_csn, input i_mosi, output o_miso);
endinterface

`default_nettype wire

// File: rtl/spi_reg_slave.sv
// ----------------------------------------------------------------------------
// spi_reg_slave : oversampled SPI slave, 16-bit frame into a 16x8 register file.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_reg_slave #(
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic            i_ck,
  input  logic            i_rstn,
  spi_reg_slave_if.slave  spi,
  input  logic [3:0]      i_loc_addr,
  output logic [7:0]      o_loc_data,
  output logic            o_wr_stb,
  output logic [3:0]      o_wr_addr,
  output logic [7:0]      o_wr_data,
  output logic            o_frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, rise_q, fall_q;
  logic                   w_csn, w_mosi;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] sout_q, sout_d;
  logic [3:0] idx_q, idx_d;
  logic       rnw_q, rnw_d;
  logic       miso_q, miso_d;
  logic       wr_stb_q, wr_stb_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       err_q, err_d;
  logic [7:0] regs_q [16];
  logic [7:0] loc_data_q;

  logic [7:0] w_shift;
  logic [7:0] w_sout_shift;
  logic       w_out_bit;

  // Synchronizers idle at 1 so reset looks like "SCLK high, CSn deasserted"
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      sclk_sync_q <= '1;
      csn_sync_q  <= '1;
      mosi_sync_q <= '1;
      sclk_prev_q <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.i_sclk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi.i_csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.i_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      fall_q      <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    end
  end

  assign w_csn  = csn_sync_q[SYNC_STAGES-1];
  assign w_mosi = mosi_sync_q[SYNC_STAGES-1];

  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_shift      = {w_mosi, shreg_q[7:1]};
      assign w_out_bit    = sout_q[0];
      assign w_sout_shift = {1'b0, sout_q[7:1]};
    end else begin : g_msb
      assign w_shift      = {shreg_q[6:0], w_mosi};
      assign w_out_bit    = sout_q[7];
      assign w_sout_shift = {sout_q[6:0], 1'b0};
    end
  endgenerate

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= 4'd0;
      shreg_q   <= 8'h00;
      sout_q    <= 8'h00;
      idx_q     <= 4'd0;
      rnw_q     <= 1'b0;
      miso_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      sout_q    <= sout_d;
      idx_q     <= idx_d;
      rnw_q     <= rnw_d;
      miso_q    <= miso_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    sout_d    = sout_q;
    idx_d     = idx_q;
    rnw_d     = rnw_q;
    miso_d    = miso_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (!w_csn) begin
          bitcnt_d = 4'd0;
          shreg_d  = 8'h00;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_csn) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (rise_q) begin
          shreg_d  = w_shift;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            idx_d    = w_shift[3:0];
            rnw_d    = w_shift[7];
            sout_d   = regs_q[w_shift[3:0]];
            bitcnt_d = 4'd0;
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_csn) begin
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (fall_q && rnw_q) begin
            miso_d = w_out_bit;
            sout_d = w_sout_shift;
          end
          if (rise_q) begin
            shreg_d  = w_shift;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (!rnw_q) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = w_shift;
              end
              miso_d  = 1'b0;
              state_d = ST_DONE;
            end
          end
        end
      end
      default: begin
        miso_d = 1'b0;
        if (w_csn) state_d = ST_IDLE;
      end
    endcase
  end

  // Commit follows the strobe, so a same-cycle local read still sees the old value
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      loc_data_q <= 8'h00;
    end else begin
      if (wr_stb_q) regs_q[wr_addr_q] <= wr_data_q;
      loc_data_q <= regs_q[i_loc_addr];
    end
  end

  assign spi.o_miso  = miso_q;
  assign o_loc_data  = loc_data_q;
  assign o_wr_stb    = wr_stb_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_frame_err = err_q;

endmodule

`default_nettype wire

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI register-file slave, the downstream endpoint of the team's SPI master. It decodes the master's 16-bit frame (8-bit address byte, then 8-bit data byte) and writes the data byte into a 16×8 register file, or returns a register's contents on MISO during the data byte. All logic runs in the `i_ck` domain: SCLK, CSn and MOSI are oversampled through synchronizers. A local read port and a write strobe expose the register file to the rest of the design.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `i_sclk`, `i_csn`, `i_mosi` (≥2).
- `LSB_FIRST`, default 0: 0 = MSB-first on both bytes; 1 = LSB-first. Must match the master's `spi_ctrl[3]` setting (inverted sense).
- `i_ck`  in  1  system clock; frequency ≥ 8× SCLK.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_sclk`  in  1  SPI clock; idles high.
- `i_csn`  in  1  chip select, active-low.
- `i_mosi`  in  1  serial data from master.
- `o_miso`  out  1  serial data to master.
- `i_loc_addr`  in  4  local read address.
- `o_loc_data`  out  8  registered read data for `i_loc_addr`, one-cycle latency.
- `o_wr_stb`  out  1  one-cycle pulse on each SPI register write.
- `o_wr_addr`  out  4  register index written; valid with `o_wr_stb`.
- `o_wr_data`  out  8  value written; valid with `o_wr_stb`.
- `o_frame_err`  out  1  one-cycle pulse on an aborted frame.

## Operation
- Address byte: bit7 = R/nW (1 = read); bits 6:4 ignored; bits 3:0 = register index.
- SPI mode: master changes MOSI on SCLK falling edge; slave samples MOSI on synchronized SCLK rising edge. Slave updates MISO on the synchronized falling edge.
- FSM states:
  - IDLE: wait for synchronized CSn low. On CSn low, clear bit counter and shift register, then go to ADDR.
  - ADDR: shift in 8 bits. On the 8th rising edge, latch the index and R/nW flag. On a read, load the shift-out register with `reg[index]`, then go to DATA.
  - DATA: shift in 8 bits. On a read, drive one output bit per falling edge; the first falling edge in DATA drives bit7 (bit0 if `LSB_FIRST`). On the 8th rising edge of a write, commit the byte to `reg[index]` and pulse `o_wr_stb`. A read commits nothing. Then go to DONE.
  - DONE: ignore further SCLK edges and wait for CSn high, then go to IDLE.
- CSn rising in ADDR or DATA: this is an abort. Pulse `o_frame_err`, perform no write, and return to IDLE.
- CSn rising in DONE: normal end of frame. No error is flagged.
- `o_miso` is 0 whenever the FSM is not in DATA with a read active. There is no tristate.
- The register file has 16×8 entries, all reset to 0x00. Writes are possible only via SPI.
- Bit counter is 4 bits wide. Edges arriving while CSn is high are ignored.

## Timing
- Reset values: all registers 0x00; FSM in IDLE; `o_miso`=0; `o_loc_data`=0x00; `o_wr_stb`=0; `o_wr_addr`=0; `o_wr_data`=0; `o_frame_err`=0; synchronizer flops=1 (idle levels).
- Input latency: SYNC_STAGES+1 `i_ck` cycles from a pin edge to its detected edge pulse.
- Write commit: `o_wr_stb` asserts SYNC_STAGES+2 `i_ck` cycles after the 16th SCLK rising edge at the pin. The register holds the new value from the following cycle.
- MISO: valid SYNC_STAGES+2 `i_ck` cycles after the SCLK falling edge at the pin. This is within a half SCLK period when `i_ck` ≥ 8× SCLK.
- Local read vs. simultaneous SPI write to the same index: `o_loc_data` returns the old value that cycle and the new value the next cycle.
- SPI read of a register while its write is committing in the same cycle: impossible, because write and read are distinct frames.
- Reset asserted mid-frame: all state returns to reset values immediately. No `o_wr_stb` and no `o_frame_err` are issued.
- Back-to-back frames: CSn high for at least SYNC_STAGES+2 `i_ck` cycles between frames. A shorter gap may be missed.

## Test plan
- Write frame: addr 0x05, data 0xA7, MSB-first → one `o_wr_stb` with `o_wr_addr`=5 and `o_wr_data`=0xA7. Then `i_loc_addr`=5 gives `o_loc_data`=0xA7; all other registers read 0x00.
- Read frame: preload reg3=0x3C, then send addr 0x83 → MISO bits during data byte are 0,0,1,1,1,1,0,0. No `o_wr_stb` pulse.
- `LSB_FIRST`=1: write addr bits for 0x0A and data bits for 0x81, both LSB-first → reg10=0x81.
- Abort: raise CSn after 11 SCLK cycles of a write to reg2 → exactly one `o_frame_err` pulse; reg2 stays 0x00. The next full frame succeeds.
- Extra clocks: 20 SCLK cycles in one CSn window, writing 0x55 to reg1 → exactly one write, reg1=0x55, no error.
- Reset mid-frame: pulse `i_rstn` low during data bit 4 → all outputs return to reset values, no strobe. The next frame writes correctly.
